// File: rtl/qspi_arb_pkg.sv
// Shared types and constants for the QSPI pin-set arbiter.
package qspi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        GUARD = 2'd3
    } arb_state_e;

    localparam int unsigned REQ_CPU = 0;
    localparam int unsigned REQ_AUX = 1;

    localparam logic [2:0] SEL_IDLE  = 3'b111;
    localparam logic [3:0] OE_IDLE   = 4'h0;
    localparam logic [3:0] DATA_IDLE = 4'h0;

    // Tie goes to the requester that did not own the bus last.
    function automatic arb_state_e arbitrate(input logic [1:0] req, input logic last_grant);
        arb_state_e nxt;
        nxt = IDLE;
        case (req)
            2'b01:   nxt = OWN0;
            2'b10:   nxt = OWN1;
            2'b11:   nxt = last_grant ? OWN0 : OWN1;
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/qspi_arb_pin_mux.sv
// Combinational selection of the pin set driven to the QSPI pads.
module qspi_arb_pin_mux
    import qspi_arb_pkg::*;
(
    input  logic [1:0] owner,
    input  logic [3:0] m0_data_out,
    input  logic [3:0] m0_data_oe,
    input  logic       m0_clk_out,
    input  logic [2:0] m0_sel,
    input  logic [3:0] m1_data_out,
    input  logic [3:0] m1_data_oe,
    input  logic       m1_clk_out,
    input  logic [2:0] m1_sel,
    output logic [3:0] spi_data_out,
    output logic [3:0] spi_data_oe,
    output logic       spi_clk_out,
    output logic [2:0] spi_sel
);

    always_comb begin
        spi_data_out = DATA_IDLE;
        spi_data_oe  = OE_IDLE;
        spi_clk_out  = 1'b0;
        spi_sel      = SEL_IDLE;
        case (owner)
            2'b01: begin
                spi_data_out = m0_data_out;
                spi_data_oe  = m0_data_oe;
                spi_clk_out  = m0_clk_out;
                spi_sel      = m0_sel;
            end
            2'b10: begin
                spi_data_out = m1_data_out;
                spi_data_oe  = m1_data_oe;
                spi_clk_out  = m1_clk_out;
                spi_sel      = m1_sel;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Transaction-level arbiter sharing one QSPI pin set between the CPU and
// an auxiliary master, with guard cycles, fairness yield and error flag.
module qspi_bus_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned MAX_HOLD     = 64
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic [1:0] yield,
    input  logic [3:0] m0_data_out,
    input  logic [3:0] m0_data_oe,
    input  logic       m0_clk_out,
    input  logic [2:0] m0_sel,
    input  logic [3:0] m1_data_out,
    input  logic [3:0] m1_data_oe,
    input  logic       m1_clk_out,
    input  logic [2:0] m1_sel,
    output logic [3:0] spi_data_out,
    output logic [3:0] spi_data_oe,
    output logic       spi_clk_out,
    output logic [2:0] spi_sel,
    output logic       err,
    input  logic       err_clr,
    output logic [1:0] owner
);

    localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES - 1);
    localparam logic [7:0] HOLD_MAX   = 8'(MAX_HOLD);

    arb_state_e state;
    arb_state_e arb_next;
    logic       last_grant;
    logic [3:0] guard_cnt;
    logic [7:0] hold_cnt;

    assign arb_next = arbitrate(req, last_grant);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            guard_cnt  <= '0;
            hold_cnt   <= '0;
            err        <= 1'b0;
        end else begin
            // A new error later in this block overrides the clear.
            if (err_clr) err <= 1'b0;
            case (state)
                IDLE, GUARD: begin
                    hold_cnt <= '0;
                    if (state == GUARD && guard_cnt != '0) begin
                        guard_cnt <= guard_cnt - 4'd1;
                    end else begin
                        state <= arb_next;
                        if (arb_next == OWN0) last_grant <= 1'b0;
                        if (arb_next == OWN1) last_grant <= 1'b1;
                    end
                end
                OWN0: begin
                    if (!req[REQ_CPU]) begin
                        state     <= GUARD;
                        guard_cnt <= GUARD_LOAD;
                        if (m0_sel != SEL_IDLE) err <= 1'b1;
                    end else if (req[REQ_AUX] && hold_cnt < HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                OWN1: begin
                    if (!req[REQ_AUX]) begin
                        state     <= GUARD;
                        guard_cnt <= GUARD_LOAD;
                        if (m1_sel != SEL_IDLE) err <= 1'b1;
                    end else if (req[REQ_CPU] && hold_cnt < HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gnt   = {state == OWN1, state == OWN0};
    assign owner = gnt;
    assign yield = {state == OWN1 && hold_cnt == HOLD_MAX,
                    state == OWN0 && hold_cnt == HOLD_MAX};

    qspi_arb_pin_mux u_pin_mux (
        .owner        (owner),
        .m0_data_out  (m0_data_out),
        .m0_data_oe   (m0_data_oe),
        .m0_clk_out   (m0_clk_out),
        .m0_sel       (m0_sel),
        .m1_data_out  (m1_data_out),
        .m1_data_oe   (m1_data_oe),
        .m1_clk_out   (m1_clk_out),
        .m1_sel       (m1_sel),
        .spi_data_out (spi_data_out),
        .spi_data_oe  (spi_data_oe),
        .spi_clk_out  (spi_clk_out),
        .spi_sel      (spi_sel)
    );

endmodule
